// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types, constants and helpers for uart_tx/uart_rx.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } uart_state_e;

    // Everything a frame needs, captured at accept time.
    typedef struct packed {
        logic [UART_DATA_W-1:0] data;
        logic                   par_en;
        logic                   par_bit;
        logic                   stop2;
    } tx_frame_t;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic tx_frame_t make_frame(
        input logic [UART_DATA_W-1:0] data,
        input logic                   par_en,
        input logic                   par_sel,
        input logic                   stop_bits
    );
        tx_frame_t f;
        f.data    = data;
        f.par_en  = par_en;
        f.par_bit = (^data) ^ ~par_sel;
        f.stop2   = stop_bits;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Loadable down-counter, one-cycle tick every DIV cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic tick_o
);

    localparam int             CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_baud_gen: DIV must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A load restarts the period so the first bit of a frame is a full DIV long.
    always_comb begin
        cnt_d = cnt_q - CNT_W'(1);
        if (load_i || (cnt_q == '0)) begin
            cnt_d = CNT_MAX;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter, 8N/E/O with 1 or 2 stop bits.
//               Define UART_TX_HOLD_EN for a one-entry holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int p_clk_speed_hz = 50_000_000,
    parameter int p_baud_rate    = 9_600
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic [UART_DATA_W-1:0] data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   parity_en_i,
    input  logic                   parity_sel_i,
    input  logic                   stop_bits_i,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int               DIV      = calc_div(p_clk_speed_hz, p_baud_rate);
    localparam int               IDX_W    = $clog2(UART_DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_W - 1);

    uart_state_e      state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    tx_frame_t        frame_q, frame_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;

    tx_frame_t        in_frame;
    logic             accept;
    logic             tick;
    logic             start_frame;
    logic             frame_end;

`ifdef UART_TX_HOLD_EN
    tx_frame_t        hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    assign ready_o = enable_i && !rst_i && !hold_full_q;
`else
    assign ready_o = enable_i && !rst_i && (state_q == ST_IDLE);
`endif

    assign accept   = valid_i && ready_o;
    assign in_frame = make_frame(data_i, parity_en_i, parity_sel_i, stop_bits_i);
    assign busy_o   = (state_q != ST_IDLE);
    assign tx_o     = tx_q;
    assign done_o   = done_q;

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (start_frame),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            frame_q   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            frame_q   <= frame_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

`ifdef UART_TX_HOLD_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        frame_d     = frame_q;
        start_frame = 1'b0;
        frame_end   = 1'b0;
`ifdef UART_TX_HOLD_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    frame_d     = in_frame;
                    state_d     = ST_START;
                    start_frame = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = frame_q.par_en ? ST_PARITY : ST_STOP1;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (tick) begin
                    if (frame_q.stop2) begin
                        state_d = ST_STOP2;
                    end else begin
                        state_d   = ST_IDLE;
                        frame_end = 1'b1;
                    end
                end
            end
            ST_STOP2: begin
                if (tick) begin
                    state_d   = ST_IDLE;
                    frame_end = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef UART_TX_HOLD_EN
        // Chain straight into the next frame so there is no idle gap.
        if (frame_end) begin
            if (hold_full_q) begin
                frame_d     = hold_q;
                state_d     = ST_START;
                start_frame = 1'b1;
                hold_full_d = 1'b0;
            end else if (accept) begin
                frame_d     = in_frame;
                state_d     = ST_START;
                start_frame = 1'b1;
            end
        end
        if (accept && (state_q != ST_IDLE) && !(frame_end && !hold_full_q)) begin
            hold_d      = in_frame;
            hold_full_d = 1'b1;
        end
`endif
    end

    // Line level is registered from the next state so tx_o is glitch-free.
    always_comb begin
        tx_d   = 1'b1;
        done_d = frame_end;
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = frame_d.data[bit_idx_d];
            ST_PARITY: tx_d = frame_d.par_bit;
            default:   tx_d = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Scoreboard bench for uart_tx (DIV=10); honours UART_TX_HOLD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_HOLD_EN
    localparam int EXP_GAP = 0;
`else
    localparam int EXP_GAP = 1;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       ps;
        logic       sb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       pe, ps, sb;
    logic       tx, busy, done;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    bit          in_frame = 1'b0;
    int          off = 0;
    int          nbits = 0;
    exp_t        cur;
    logic [11:0] exp_vec, got_vec;
    int          hold_err = 0, ctl_err = 0;
    logic        prev_tx = 1'b1;
    int          last_done_cyc = 0;
    bit          last_done_valid = 1'b0;
    bit          check_gap = 1'b0;

    always #5 clk = ~clk;

    uart_tx #(
        .p_clk_speed_hz (CLK_HZ),
        .p_baud_rate    (BAUD)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .data_i       (data),
        .valid_i      (valid),
        .ready_o      (ready),
        .parity_en_i  (pe),
        .parity_sel_i (ps),
        .stop_bits_i  (sb),
        .tx_o         (tx),
        .busy_o       (busy),
        .done_o       (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference frame: start, LSB-first data, optional parity, then stop ones.
    function automatic logic [11:0] model_bits(input exp_t e);
        logic [11:0] v    = '1;
        int          ones = $countones(e.d);
        v[0] = 1'b0;
        for (int i = 0; i < 8; i++) v[i+1] = e.d[i];
        if (e.pe) v[9] = e.ps ? ((ones % 2) == 1) : ((ones % 2) == 0);
        return v;
    endfunction

    task automatic sample();
        int k = off / DIV;
        if (tx !== exp_vec[k]) hold_err++;
        if ((off % DIV) == (DIV / 2)) got_vec[k] = tx;
        if (busy !== 1'b1 || (off != 0 && done !== 1'b0)) ctl_err++;
        off++;
    endtask

    always @(negedge clk) begin : mon
        bit ended;
        ended = 1'b0;
        cyc++;
        if (rst) begin
            in_frame = 1'b0;
            prev_tx  = 1'b1;
        end else begin
            if (in_frame) begin
                if (off < nbits * DIV) begin
                    sample();
                end else begin
                    check($sformatf("frame_bits d=%02h", cur.d), 32'(got_vec), 32'(exp_vec));
                    check("frame_hold", hold_err, 0);
                    check("frame_ctl", ctl_err, 0);
                    check("frame_done", 32'(done), 1);
                    in_frame        = 1'b0;
                    ended           = 1'b1;
                    last_done_cyc   = cyc;
                    last_done_valid = 1'b1;
                end
            end
            if (!ended && !in_frame && done === 1'b1) check("spurious_done", 32'(done), 0);
            if (!in_frame && prev_tx === 1'b1 && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    cur      = exp_q.pop_front();
                    nbits    = 10 + int'(cur.pe) + int'(cur.sb);
                    exp_vec  = model_bits(cur);
                    got_vec  = '1;
                    hold_err = 0;
                    ctl_err  = 0;
                    if (check_gap && last_done_valid) check("frame_gap", cyc - last_done_cyc, EXP_GAP);
                    in_frame = 1'b1;
                    off      = 0;
                    sample();
                end
            end
            prev_tx = tx;
        end
    end

    task automatic send(input logic [7:0] d, input logic e_pe, input logic e_ps, input logic e_sb);
        int n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            check("send_ready_timeout", 32'(ready), 1);
            return;
        end
        data  = d;
        pe    = e_pe;
        ps    = e_ps;
        sb    = e_sb;
        valid = 1'b1;
        exp_q.push_back({d, e_pe, e_ps, e_sb});
        @(posedge clk);
        #1;
        valid = 1'b0;
        data  = 8'($urandom);
        pe    = 1'($urandom);
        ps    = 1'($urandom);
        sb    = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || in_frame || busy === 1'b1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("idle_timeout", n, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [7:0] hello [5];
        int         err;
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        rst = 1'b1; enable = 1'b1; valid = 1'b0; data = '0; pe = 0; ps = 0; sb = 0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 1);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_ready", 32'(ready), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(ready), 1);

        send(8'h48, 1'b1, 1'b1, 1'b0); wait_idle();
        send(8'h45, 1'b1, 1'b0, 1'b1); wait_idle();
        send(8'hFF, 1'b0, 1'($urandom), 1'b0); wait_idle();

        check_gap = 1'b1; last_done_valid = 1'b0;
        for (int i = 0; i < 5; i++) send(hello[i], 1'($urandom), 1'($urandom), 1'($urandom));
        wait_idle();
        check_gap = 1'b0;

        enable = 1'b0; valid = 1'b1; data = 8'($urandom);
        err = 0;
        repeat (60) begin
            @(negedge clk);
            if (ready !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) err++;
        end
        check("disabled_hold", err, 0);
        valid = 1'b0; enable = 1'b1;
        send(8'($urandom), 1'b1, 1'($urandom), 1'b1);
        repeat (3 * DIV) @(negedge clk);
        enable = 1'b0;
        wait_idle();
        check("disabled_ready", 32'(ready), 0);
        enable = 1'b1;

        send(8'h00, 1'b1, 1'b1, 1'b0);
        repeat (3 * DIV + 3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_tx", 32'(tx), 1);
        check("rst_async_busy", 32'(busy), 0);
        err = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) err++;
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2 * DIV) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) err++;
        end
        check("rst_no_done", err, 0);
        send(8'hA5, 1'b1, 1'b0, 1'b0); wait_idle();

        for (int i = 0; i < 20; i++) begin
            send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(1, 0) == 0) wait_idle();
        end
        wait_idle();
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the sending end of the team's `uart_rx`. It accepts a byte over a valid/ready handshake and serialises it onto `tx_o`:

- one start bit, then 8 data bits LSB first;
- an optional parity bit;
- one or two stop bits.

Framing options and baud parameters match `uart_rx`, so a `uart_tx` → `uart_rx` loopback is the primary integration check.

## Interface
- `p_clk_speed_hz`, default 50_000_000, clock frequency in Hz.
- `p_baud_rate`, default 9_600, line rate in baud.
- `clk_i`  in  1  system clock, one clock domain.
- `rst_i`  in  1  asynchronous, active-high reset.
- `enable_i`  in  1  permits acceptance of new bytes.
- `data_i`  in  8  byte to send.
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  block can accept a byte this cycle.
- `parity_en_i`  in  1  append parity bit.
- `parity_sel_i`  in  1  1 = even parity, 0 = odd parity.
- `stop_bits_i`  in  1  0 = one stop bit, 1 = two stop bits.
- `tx_o`  out  1  serial line, idle high; registered.
- `busy_o`  out  1  a frame is on the line.
- `done_o`  out  1  one-cycle pulse when the final stop bit completes.

## Operation
- **Bit period.** `DIV = p_clk_speed_hz / p_baud_rate`, integer division, truncated. `DIV` must be ≥ 2 (elaboration-time assertion). The baud counter is `$clog2(DIV)` bits wide and counts `DIV-1` down to 0.
- **Accept.** A byte is accepted when `valid_i && ready_o`. On accept, `data_i`, `parity_en_i`, `parity_sel_i` and `stop_bits_i` are latched. Input changes mid-frame have no effect.
- **Parity.** Parity bit = `^data` XOR `~parity_sel_i`.
- **FSM states:** IDLE → START → DATA (8 bits, bit index 0..7) → PARITY (only if enabled) → STOP1 → STOP2 (only if `stop_bits_i`) → IDLE.
- **Line levels per state.** START drives 0. DATA drives `data[idx]`. STOP1 and STOP2 drive 1. IDLE drives 1.
- **`enable_i`.** Deasserting it only blocks new accepts. A frame in flight always completes and is never truncated.
- **`ready_o`.** `enable_i && state==IDLE`.
- **`busy_o`.** 1 in every state except IDLE.
- **Reset values:** `tx_o`=1, `busy_o`=0, `done_o`=0, `ready_o`=0. FSM goes to IDLE and the counters clear.
- **Reset mid-frame.** The frame is aborted and `tx_o` returns high asynchronously. No `done_o` pulse is produced.

## Timing
- Accept at edge N: `tx_o` falls at edge N+1 and `busy_o` is 1 from edge N+1.
- Each bit holds for exactly `DIV` cycles.
- Frame length is `DIV*(10 + parity_en + stop_bits)` cycles.
- `done_o` is high for the one cycle after the final stop bit's last cycle. In that same cycle the FSM is in IDLE and `ready_o`=`enable_i`.
- Back-to-back frames, without hold register: accept possible in that done cycle, so there is a 1-cycle idle-high gap between frames.

## Configuration
- **`UART_TX_HOLD_EN` defined:** adds a one-entry holding register.
  - `ready_o = enable_i && !hold_full`, so a byte can be accepted during a frame.
  - The held byte is loaded when the last stop bit ends and its start bit begins on the next cycle. There is no idle gap.
  - `done_o` still pulses once per frame.
  - Simultaneous accept and load in the same cycle is allowed; `hold_full` stays 1.
- **Undefined:** no holding register; behaviour exactly as above.

## Structure
- **Shared package `uart_pkg`:**
  - state enum `uart_state_e`, shared with `uart_rx`;
  - function `calc_div(clk_hz, baud)`;
  - `UART_DATA_W = 8`.
- **Sub-module `uart_baud_gen`:** loadable down-counter producing a one-cycle `tick` every `DIV` cycles. It restarts on frame start so the start bit is exactly `DIV` cycles long. The same module is reusable by `uart_rx`.

## Test plan
All scenarios use `p_clk_speed_hz=1_000_000`, `p_baud_rate=100_000`, giving `DIV=10`.

1. **Even parity, one stop bit.**
   - Stimulus: send 0x48 with `parity_en=1`, `parity_sel=1`, `stop_bits=0`.
   - Required: `tx_o` sampled at bit centres reads 0, 0,0,0,1,0,0,1,0, 0, 1.
   - Frame is 110 cycles; `done_o` pulses at cycle 111.
2. **Odd parity, two stop bits.**
   - Stimulus: send 0x45 with `parity_sel=0`, `stop_bits=1`.
   - Required: parity bit 0, two high stop bits, frame is 120 cycles.
3. **Loopback with `uart_rx`.**
   - Stimulus: send "HELLO" back-to-back through `uart_tx` into `uart_rx`.
   - Required: each byte is read back with no parity or framing errors. Without `UART_TX_HOLD_EN` the gap between frames is exactly 1 cycle; with it, 0 cycles.
4. **Enable control.**
   - Stimulus: hold `enable_i=0` with `valid_i=1`; later drop `enable_i` mid-frame.
   - Required: `ready_o` stays 0 and `tx_o` stays 1 while disabled. When `enable_i` drops mid-frame, the frame completes and `done_o` pulses.
5. **Reset mid-frame.**
   - Stimulus: assert `rst_i` during the DATA state.
   - Required: `tx_o`=1 and `busy_o`=0 immediately with no `done_o` pulse. After reset, the next byte transmits correctly.
6. **Parity disabled.**
   - Stimulus: send 0xFF with `parity_en=0`.
   - Required: frame is 100 cycles and there is no parity bit.
